// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: gate codes, flit type codes, flit field
// positions, arbiter state encoding and the mod-5 round-robin step helper.
package noc_pkg;

    localparam logic [2:0] GATE_N  = 3'd0;
    localparam logic [2:0] GATE_E  = 3'd1;
    localparam logic [2:0] GATE_S  = 3'd2;
    localparam logic [2:0] GATE_W  = 3'd3;
    localparam logic [2:0] GATE_PE = 3'd4;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;
    localparam logic [1:0] FT_HSK  = 2'b11;

    localparam int FLIT_TYPE_HI = 31;
    localparam int FLIT_TYPE_LO = 30;
    localparam int FLIT_SRC_HI  = 29;
    localparam int FLIT_SRC_LO  = 26;
    localparam int FLIT_DST_HI  = 25;
    localparam int FLIT_DST_LO  = 22;

    localparam int NUM_INPUTS = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // (base + step) mod 5 for base in 0..4 and step in 0..5
    function automatic logic [2:0] rr_step(input logic [2:0] base, input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 4'd5) begin
            return 3'(sum - 4'd5);
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Request/grant bundle between the five router inputs and one output arbiter.
interface noc_out_arbiter_if;

    logic [4:0]  valid_in;
    logic [14:0] gate_in;
    logic [9:0]  type_in;
    logic        out_ready;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        locked;
    logic [7:0]  pkt_count;
    logic        err;

    modport master (
        output valid_in, gate_in, type_in, out_ready,
        input  grant, sel, locked, pkt_count, err
    );

    modport slave (
        input  valid_in, gate_in, type_in, out_ready,
        output grant, sel, locked, pkt_count, err
    );

endinterface

// File: rtl/noc_out_arbiter_rr_pick5.sv
// Combinational 5-way round-robin picker: searches ptr+1, ptr+2, ... mod 5
// and reports the first requesting index.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic       found,
    output logic [2:0] winner
);

    logic [2:0] cand;

    // Walk the rotated priority order and keep the first hit
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        cand   = 3'd0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = rr_step(ptr, 3'(k));
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output-port wormhole arbiter: grants one input round-robin, holds the
// port from header to tail, releases on tail or single-flit handshake.
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter logic [2:0] PORT = 3'd0
)(
    input  logic               clk,
    input  logic               enable,
    noc_out_arbiter_if.slave   bus
);

    arb_state_t  state;
    logic [2:0]  ptr;
    logic [4:0]  grant_q;
    logic [2:0]  sel_q;
    logic        locked_q;
    logic [7:0]  pkt_count_q;
    logic        err_q;

    logic [4:0]  req;
    logic [4:0]  qual;
    logic [4:0]  bad;
    logic        found;
    logic [2:0]  winner;
    logic [1:0]  cur_type;
    logic        xfer;
    logic        last_flit;

    // Decode per-input requests aimed at this port; U-turns never request
    always_comb begin
        req  = '0;
        qual = '0;
        bad  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req[i]  = bus.valid_in[i] && (bus.gate_in[3*i +: 3] == PORT) && (3'(i) != PORT);
            qual[i] = req[i] && ((bus.type_in[2*i +: 2] == FT_HEAD) || (bus.type_in[2*i +: 2] == FT_HSK));
            bad[i]  = req[i] && !qual[i];
        end
    end

    rr_pick5 u_pick (
        .req    (qual),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // Transfer detection for the owning input's head flit
    always_comb begin
        cur_type  = bus.type_in[2*int'(sel_q) +: 2];
        xfer      = bus.valid_in[sel_q] && bus.out_ready;
        last_flit = (cur_type == FT_TAIL) || (cur_type == FT_HSK);
    end

    // Arbitration FSM with registered grant/sel/locked, packet counter and error flag
    always_ff @(posedge clk) begin
        if (!enable) begin
            state       <= ST_IDLE;
            ptr         <= 3'd4;
            grant_q     <= '0;
            sel_q       <= '0;
            locked_q    <= 1'b0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bad) begin
                        err_q <= 1'b1;
                    end
                    if (found) begin
                        grant_q  <= 5'd1 << winner;
                        sel_q    <= winner;
                        locked_q <= 1'b1;
                        state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (xfer && last_flit) begin
                        grant_q     <= '0;
                        locked_q    <= 1'b0;
                        ptr         <= sel_q;
                        pkt_count_q <= pkt_count_q + 8'd1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.locked    = locked_q;
    assign bus.pkt_count = pkt_count_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter at PORT=1 (east gate): directed
// vectors push hand-computed post-edge expectations, a monitor pops and checks.
module tb_noc_out_arbiter;
    import noc_pkg::*;

    typedef struct {
        logic [4:0] grant;
        logic [2:0] sel;
        logic       locked;
        logic [7:0] pkt;
        logic       err;
        string      name;
    } exp_t;

    logic clk;
    logic enable;
    noc_out_arbiter_if bus();

    logic [4:0]  nxtValid;
    logic [14:0] nxtGate;
    logic [9:0]  nxtType;

    exp_t expQ[$];
    int   checks;
    int   errors;

    noc_out_arbiter #(.PORT(GATE_E)) dut (
        .clk    (clk),
        .enable (enable),
        .bus    (bus.slave)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running want=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic setIn(input int i, input logic v, input logic [2:0] g, input logic [1:0] t);
        nxtValid[i]       = v;
        nxtGate[3*i +: 3] = g;
        nxtType[2*i +: 2] = t;
    endtask

    task automatic clearIn();
        nxtValid = '0;
        nxtGate  = '0;
        nxtType  = '0;
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge
    task automatic applyStimulus(input logic ready, input logic en,
                                 input logic [4:0] g, input logic [2:0] s,
                                 input logic l, input logic [7:0] p,
                                 input logic e, input string name);
        exp_t item;
        @(posedge clk);
        #2;
        bus.valid_in  = nxtValid;
        bus.gate_in   = nxtGate;
        bus.type_in   = nxtType;
        bus.out_ready = ready;
        enable        = en;
        item.grant  = g;
        item.sel    = s;
        item.locked = l;
        item.pkt    = p;
        item.err    = e;
        item.name   = name;
        expQ.push_back(item);
    endtask

    task automatic checkOutput(input exp_t item);
        checks++;
        if (bus.grant !== item.grant) begin
            errors++;
            $display("[TB] FAIL %s.grant got=%b want=%b", item.name, bus.grant, item.grant);
        end
        checks++;
        if (bus.sel !== item.sel) begin
            errors++;
            $display("[TB] FAIL %s.sel got=%0d want=%0d", item.name, bus.sel, item.sel);
        end
        checks++;
        if (bus.locked !== item.locked) begin
            errors++;
            $display("[TB] FAIL %s.locked got=%b want=%b", item.name, bus.locked, item.locked);
        end
        checks++;
        if (bus.pkt_count !== item.pkt) begin
            errors++;
            $display("[TB] FAIL %s.pkt_count got=%0d want=%0d", item.name, bus.pkt_count, item.pkt);
        end
        checks++;
        if (bus.err !== item.err) begin
            errors++;
            $display("[TB] FAIL %s.err got=%b want=%b", item.name, bus.err, item.err);
        end
    endtask

    // Monitor: one edge after each stimulus cycle, pop and compare
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        int winners[4];
        int p;
        checks = 0;
        errors = 0;
        clearIn();
        bus.valid_in  = '0;
        bus.gate_in   = '0;
        bus.type_in   = '0;
        bus.out_ready = 1'b0;
        enable        = 1'b0;

        $display("[TB] reset");
        applyStimulus(1, 0, 5'b00000, 0, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 5'b00000, 0, 0, 0, 0, "reset1");

        $display("[TB] single packet from input 0");
        setIn(0, 1, GATE_E, FT_HEAD);
        applyStimulus(1, 1, 5'b00001, 0, 1, 0, 0, "t1_grant");
        applyStimulus(1, 1, 5'b00001, 0, 1, 0, 0, "t1_head_xfer");
        setIn(0, 1, GATE_E, FT_BODY);
        applyStimulus(1, 1, 5'b00001, 0, 1, 0, 0, "t1_body");
        setIn(0, 1, GATE_E, FT_TAIL);
        applyStimulus(1, 1, 5'b00000, 0, 0, 1, 0, "t1_tail");
        clearIn();
        applyStimulus(1, 1, 5'b00000, 0, 0, 1, 0, "t1_idle");

        $display("[TB] contention 0/2/4 with U-turn input 1");
        applyStimulus(1, 0, 5'b00000, 0, 0, 0, 0, "t2_rst");
        setIn(0, 1, GATE_E, FT_HSK);
        setIn(1, 1, GATE_E, FT_HSK);
        setIn(2, 1, GATE_E, FT_HSK);
        setIn(4, 1, GATE_E, FT_HSK);
        winners = '{0, 2, 4, 0};
        p = 0;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1, 1, 5'(1 << winners[j]), 3'(winners[j]), 1, 8'(p), 0, "t2_grant");
            p++;
            applyStimulus(1, 1, 5'b00000, 3'(winners[j]), 0, 8'(p), 0, "t2_gap");
        end
        clearIn();
        applyStimulus(1, 1, 5'b00000, 0, 0, 4, 0, "t2_quiet");

        $display("[TB] stall and bubble on input 3");
        setIn(3, 1, GATE_E, FT_HEAD);
        applyStimulus(1, 1, 5'b01000, 3, 1, 4, 0, "t3_grant");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 1, 5'b01000, 3, 1, 4, 0, "t3_stall");
        end
        applyStimulus(1, 1, 5'b01000, 3, 1, 4, 0, "t3_head_xfer");
        setIn(3, 0, GATE_E, FT_BODY);
        setIn(0, 1, GATE_E, FT_HSK);
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1, 1, 5'b01000, 3, 1, 4, 0, "t3_bubble");
        end
        setIn(0, 0, GATE_N, FT_BODY);
        setIn(3, 1, GATE_E, FT_BODY);
        applyStimulus(1, 1, 5'b01000, 3, 1, 4, 0, "t3_body");
        setIn(3, 1, GATE_E, FT_TAIL);
        applyStimulus(0, 1, 5'b01000, 3, 1, 4, 0, "t3_tail_stall");
        applyStimulus(1, 1, 5'b00000, 3, 0, 5, 0, "t3_tail");
        clearIn();
        applyStimulus(1, 1, 5'b00000, 3, 0, 5, 0, "t3_quiet");

        $display("[TB] protocol error from input 2");
        setIn(2, 1, GATE_E, FT_BODY);
        applyStimulus(1, 1, 5'b00000, 3, 0, 5, 1, "t4_err");
        clearIn();
        applyStimulus(1, 1, 5'b00000, 3, 0, 5, 1, "t4_sticky");
        applyStimulus(1, 1, 5'b00000, 3, 0, 5, 1, "t4_sticky");

        $display("[TB] reset mid-packet");
        setIn(0, 1, GATE_E, FT_HEAD);
        applyStimulus(1, 1, 5'b00001, 0, 1, 5, 1, "t5_grant");
        applyStimulus(1, 1, 5'b00001, 0, 1, 5, 1, "t5_head_xfer");
        setIn(0, 1, GATE_E, FT_BODY);
        applyStimulus(1, 1, 5'b00001, 0, 1, 5, 1, "t5_body");
        applyStimulus(1, 1, 5'b00001, 0, 1, 5, 1, "t5_body");
        setIn(0, 1, GATE_E, FT_TAIL);
        applyStimulus(1, 0, 5'b00000, 0, 0, 0, 0, "t5_reset");
        setIn(0, 1, GATE_E, FT_HSK);
        setIn(4, 1, GATE_E, FT_HSK);
        applyStimulus(1, 1, 5'b00001, 0, 1, 0, 0, "t5_ptr4");
        applyStimulus(1, 1, 5'b00000, 0, 0, 1, 0, "t5_release");
        applyStimulus(1, 1, 5'b10000, 4, 1, 1, 0, "t5_next");
        applyStimulus(1, 1, 5'b00000, 4, 0, 2, 0, "t5_release2");
        clearIn();

        $display("[TB] packet counter wrap");
        applyStimulus(1, 0, 5'b00000, 0, 0, 0, 0, "t6_rst");
        setIn(2, 1, GATE_E, FT_HSK);
        for (int n = 0; n < 256; n++) begin
            applyStimulus(1, 1, 5'b00100, 2, 1, 8'(n), 0, "t6_grant");
            applyStimulus(1, 1, 5'b00000, 2, 0, 8'(n + 1), 0, "t6_done");
        end
        clearIn();
        applyStimulus(1, 1, 5'b00000, 2, 0, 0, 0, "t6_wrapped");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got=%0d want=0 pending", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Per-output-port wormhole arbiter for the 3x3 mesh router. Each of the five router inputs (N, E, S, W, PE) presents its head flit's type and its computed output gate. One instance per output port selects one requesting input round-robin, locks the port to it from header to tail, and drives the per-input grant and crossbar select. It releases the port on tail or single-flit handshake.

## Interface
- `PORT`, default 3'd0: gate code this instance serves (0=N, 1=E, 2=S, 3=W, 4=PE).
- `clk` in 1: clock, rising edge.
- `enable` in 1: synchronous active-low reset. Low at a rising edge resets the block.
- `valid_in` in 5: bit i = input i holds a flit at its head.
- `gate_in` in 15: gate code requested by input i, at [3i+2:3i].
- `type_in` in 10: flit[31:30] of input i's head flit, at [2i+1:2i].
- `out_ready` in 1: downstream accepts a flit this cycle.
- `grant` out 5: one-hot; bit i = input i owns this port. Registered.
- `sel` out 3: index of the owning input, for the crossbar mux. Registered.
- `locked` out 1: port is owned (state LOCK).
- `pkt_count` out 8: completed packets, wraps 255→0.
- `err` out 1: sticky protocol-error flag.

## Operation
- Flit types on `type_in`:
  - 2'b10: header.
  - 2'b00: body.
  - 2'b01: tail.
  - 2'b11: single-flit handshake.
- `req[i] = valid_in[i] & (gate_in[i] == PORT) & (i != PORT)`. There are no U-turns, so input index i == PORT never requests.
- A request qualifies only if `type_in[i]` is 10 or 11.
  - In IDLE, a req[i] with type 00 or 01 is ignored and sets `err`.
- Round-robin pointer `ptr` (3 bits) holds the last granted index.
  - Priority order is ptr+1, ptr+2, … mod 5.
- State IDLE:
  - Outputs: `grant`=0, `locked`=0.
  - If any qualified req exists, pick the winner w. At the next edge: `grant`=1<<w, `sel`=w, state LOCK.
- State LOCK:
  - `grant` and `sel` are held.
  - A transfer occurs in a cycle where `valid_in[sel] & out_ready`.
  - Transfer with type 01 or 11: at that edge, `grant`=0, state IDLE, `ptr`=sel, `pkt_count`+=1.
  - Transfer with type 00 or 10: stay in LOCK.
  - `valid_in[sel]` low (upstream bubble) or `out_ready` low: hold the lock with no change.
  - Requests from other inputs are ignored while locked.
- `err` clears only on reset.

## Timing
- Reset values: `grant`=0, `sel`=0, `locked`=0, `pkt_count`=0, `err`=0, `ptr`=4 (so input 0 has top priority first), state IDLE.
- Grant latency: a qualified req sampled at edge N produces `grant` visible after edge N.
- Release: after a tail or handshake transfer at edge T, `grant` is low during cycle T+1 (one mandatory idle cycle). The earliest next grant appears after edge T+1.
- A single-flit handshake occupies the port for at least 2 cycles: 1 granted cycle plus 1 idle cycle.
- Simultaneous requests: exactly one winner, chosen by rotating priority. No input wins twice in a row while another qualified requester is waiting.
- Reset mid-packet: `enable` low at any edge forces the reset values at that edge, even in LOCK. Reset dominates a simultaneous tail transfer, so `pkt_count` is not incremented.
- `pkt_count` wraps silently at 255→0.

## Structure
- Shared package `noc_pkg`:
  - Gate codes GATE_N/E/S/W/PE.
  - Flit type codes FT_HEAD/BODY/TAIL/HSK.
  - Flit field positions: type [31:30], source [29:26], dest [25:22].
- Sub-module `rr_pick5`: combinational 5-way round-robin picker. Inputs are the 5-bit req and 3-bit ptr; outputs are a found flag and a 3-bit winner. The FSM, counters and registers stay in `noc_out_arbiter`.

## Test plan
- Reset, then set PORT=1. Input 0 presents a header to gate 1 with `out_ready`=1, then body, then tail. Required: `grant`=5'b00001 one cycle after the request. `pkt_count`=1 after the tail edge. `grant`=0 for one cycle after the tail.
- Contention, PORT=1: inputs 0, 2 and 4 all present handshakes to gate 1 continuously. Required: grant order 0, 2, 4, 0, each grant lasting 1 cycle with 1 idle cycle between grants. Input 1 (U-turn) is never granted.
- Stall and bubble: while locked to input 3, drop `out_ready` for 3 cycles, then drop `valid_in[3]` for 2 cycles. Required: `grant`=5'b01000 held throughout, `pkt_count` unchanged until the tail transfers.
- Protocol error: in IDLE, input 2 presents a body flit to PORT. Required: no grant, `err`=1 next cycle and it stays 1.
- Reset mid-packet: assert `enable`=0 while locked after 2 body flits. Required: next cycle `grant`=0, `locked`=0, `ptr`=4, `pkt_count`=0.
- Counter wrap: send 256 handshakes. Required: `pkt_count` returns to 0.
